rob: RTL and testbench

Reorder buffer for the R10000-style out-of-order core: circular queue of in-flight instructions allocated at dispatch, marked complete by writeback, retired in order. Consumer end of the free-list handshake: takes the newly allocated physical register (T) and the previous mapping (Told) at dispatch, and returns Told to the free list at retire. On branch rollback, squashes younger entries and returns the free-list tail snapshot for the free list to restore.

---
 rtl/rob.sv | 136 +++++++++++++
 tb/tb_rob.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, in-order retire, branch rollback.
// Define ROB_DEBUG_PORTS_EN to expose head, tail and count as outputs.
module rob #(
  parameter  int NUM_ROB = 8,
  parameter  int NUM_PR  = 64,
  parameter  int NUM_FL  = 32,
  localparam int ROBW    = $clog2(NUM_ROB),
  localparam int PRW     = $clog2(NUM_PR),
  localparam int FLW     = $clog2(NUM_FL)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dispatch_en,
  input  logic [PRW-1:0]  dispatch_T_idx,
  input  logic [PRW-1:0]  dispatch_Told_idx,
  input  logic [4:0]      dispatch_dest_idx,
  input  logic [FLW-1:0]  dispatch_FL_idx,
  input  logic            complete_en,
  input  logic [ROBW-1:0] complete_ROB_idx,
  input  logic            rollback_en,
  input  logic [ROBW-1:0] rollback_ROB_idx,
  output logic            ROB_valid,
  output logic [ROBW-1:0] ROB_idx,
  output logic            retire_en,
  output logic [PRW-1:0]  retire_Told_idx,
  output logic [PRW-1:0]  retire_T_idx,
  output logic [4:0]      retire_dest_idx,
  output logic [FLW-1:0]  FL_rollback_idx
`ifdef ROB_DEBUG_PORTS_EN
  ,
  output logic [ROBW-1:0] head,
  output logic [ROBW-1:0] tail,
  output logic [ROBW:0]   count
`endif
);

  localparam logic [ROBW:0] FULL = (ROBW+1)'(NUM_ROB);

  logic [ROBW-1:0]    head_q, tail_q;
  logic [ROBW:0]      count_q;
  logic [NUM_ROB-1:0] valid, complete;
  logic [NUM_ROB-1:0] valid_nx, complete_nx, squash;
  logic [ROBW-1:0]    rb_age;
  logic               dispatch_ok;

  logic [PRW-1:0]  t_mem    [NUM_ROB];
  logic [PRW-1:0]  told_mem [NUM_ROB];
  logic [4:0]      dest_mem [NUM_ROB];
  logic [FLW-1:0]  fl_mem   [NUM_ROB];

  // Payload outputs are forced to zero while reset is held, since payload is never cleared.
  always_comb begin
    retire_en       = reset & valid[head_q] & complete[head_q];
    ROB_valid       = (count_q != FULL) || retire_en;
    ROB_idx         = tail_q;
    retire_T_idx    = reset ? t_mem[head_q]    : '0;
    retire_Told_idx = reset ? told_mem[head_q] : '0;
    retire_dest_idx = reset ? dest_mem[head_q] : '0;
    FL_rollback_idx = reset ? fl_mem[rollback_ROB_idx] : '0;
  end

  assign dispatch_ok = dispatch_en & ROB_valid & ~rollback_en;
  assign rb_age      = rollback_ROB_idx - head_q;

  // Entries whose age from head exceeds the branch's age are younger than the branch.
  always_comb begin
    logic [ROBW-1:0] age;
    age    = '0;
    squash = '0;
    for (int i = 0; i < NUM_ROB; i++) begin
      age       = ROBW'(i) - head_q;
      squash[i] = age > rb_age;
    end
  end

  // Dispatch is applied last so a full-and-retiring ROB reuses the head slot.
  always_comb begin
    valid_nx    = valid;
    complete_nx = complete;
    if (complete_en && valid[complete_ROB_idx])
      complete_nx[complete_ROB_idx] = 1'b1;
    if (retire_en)
      valid_nx[head_q] = 1'b0;
    if (rollback_en)
      valid_nx = valid_nx & ~squash;
    if (dispatch_ok) begin
      valid_nx[tail_q]    = 1'b1;
      complete_nx[tail_q] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      valid    <= valid_nx;
      complete <= complete_nx;
      if (retire_en)
        head_q <= head_q + 1'b1;
      if (rollback_en) begin
        tail_q  <= rollback_ROB_idx + 1'b1;
        count_q <= {1'b0, rb_age} + (ROBW+1)'(1) - (ROBW+1)'(retire_en);
      end else begin
        if (dispatch_ok)
          tail_q <= tail_q + 1'b1;
        case ({dispatch_ok, retire_en})
          2'b10:   count_q <= count_q + (ROBW+1)'(1);
          2'b01:   count_q <= count_q - (ROBW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (dispatch_ok) begin
      t_mem[tail_q]    <= dispatch_T_idx;
      told_mem[tail_q] <= dispatch_Told_idx;
      dest_mem[tail_q] <= dispatch_dest_idx;
      fl_mem[tail_q]   <= dispatch_FL_idx;
    end
  end

`ifdef ROB_DEBUG_PORTS_EN
  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
`else
  // head, tail and count stay internal in this build.
`endif

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed table, hand-written corner sequences, and a queue-model random run.
module tb_rob;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dispatch_en;
  logic [5:0] dispatch_T_idx, dispatch_Told_idx;
  logic [4:0] dispatch_dest_idx, dispatch_FL_idx;
  logic       complete_en;
  logic [2:0] complete_ROB_idx;
  logic       rollback_en;
  logic [2:0] rollback_ROB_idx;
  logic       ROB_valid;
  logic [2:0] ROB_idx;
  logic       retire_en;
  logic [5:0] retire_Told_idx, retire_T_idx;
  logic [4:0] retire_dest_idx, FL_rollback_idx;

  rob dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_T_idx(dispatch_T_idx),
    .dispatch_Told_idx(dispatch_Told_idx), .dispatch_dest_idx(dispatch_dest_idx),
    .dispatch_FL_idx(dispatch_FL_idx),
    .complete_en(complete_en), .complete_ROB_idx(complete_ROB_idx),
    .rollback_en(rollback_en), .rollback_ROB_idx(rollback_ROB_idx),
    .ROB_valid(ROB_valid), .ROB_idx(ROB_idx), .retire_en(retire_en),
    .retire_Told_idx(retire_Told_idx), .retire_T_idx(retire_T_idx),
    .retire_dest_idx(retire_dest_idx), .FL_rollback_idx(FL_rollback_idx)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    dispatch_en = 0; dispatch_T_idx = 0; dispatch_Told_idx = 0;
    dispatch_dest_idx = 0; dispatch_FL_idx = 0;
    complete_en = 0; complete_ROB_idx = 0;
    rollback_en = 0; rollback_ROB_idx = 0;
  endtask

  task automatic disp(input int t, input int told, input int dest, input int fl);
    dispatch_en = 1;
    dispatch_T_idx = 6'(t); dispatch_Told_idx = 6'(told);
    dispatch_dest_idx = 5'(dest); dispatch_FL_idx = 5'(fl);
  endtask

  task automatic comp(input int idx);
    complete_en = 1; complete_ROB_idx = 3'(idx);
  endtask

  task automatic do_reset();
    @(negedge clock); idle(); reset = 0;
    @(negedge clock); reset = 1;
  endtask

  typedef struct {
    bit den; int t; bit cen; int cidx;
    bit exp_vld; int exp_idx; bit exp_ret; int exp_rt;
  } vec_t;
  vec_t tbl[12];

  typedef struct { int t; int told; int dest; int fl; bit done; } ent_t;
  ent_t q[$];
  int   mhead;

  initial begin
    idle();
    #1;
    chk("rst_valid", ROB_valid, 1);
    chk("rst_idx", ROB_idx, 0);
    chk("rst_retire", retire_en, 0);
    chk("rst_rT", retire_T_idx, 0);
    chk("rst_flrb", FL_rollback_idx, 0);
    @(negedge clock); reset = 1;

    // Table: dispatch 4, complete 2,1,0,3, in-order retire on consecutive cycles
    tbl[0]  = '{1, 32, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 33, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{1, 34, 0, 0, 1, 2, 0, 0};
    tbl[3]  = '{1, 35, 0, 0, 1, 3, 0, 0};
    tbl[4]  = '{0, 0,  1, 2, 1, 4, 0, 0};
    tbl[5]  = '{0, 0,  1, 1, 1, 4, 0, 0};
    tbl[6]  = '{0, 0,  1, 0, 1, 4, 0, 0};
    tbl[7]  = '{0, 0,  1, 3, 1, 4, 1, 32};
    tbl[8]  = '{0, 0,  0, 0, 1, 4, 1, 33};
    tbl[9]  = '{0, 0,  0, 0, 1, 4, 1, 34};
    tbl[10] = '{0, 0,  0, 0, 1, 4, 1, 35};
    tbl[11] = '{0, 0,  0, 0, 1, 4, 0, 0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clock); idle();
      if (tbl[i].den) disp(tbl[i].t, tbl[i].t + 8, tbl[i].t - 30, tbl[i].t - 31);
      if (tbl[i].cen) comp(tbl[i].cidx);
      #1;
      chk($sformatf("tbl%0d_valid", i), ROB_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_idx", i), ROB_idx, tbl[i].exp_idx);
      chk($sformatf("tbl%0d_ret", i), retire_en, tbl[i].exp_ret);
      if (tbl[i].exp_ret) chk($sformatf("tbl%0d_rT", i), retire_T_idx, tbl[i].exp_rt);
    end

    // Fill to full, ignored 9th dispatch, retire+dispatch into the head slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); idle(); disp(32 + i, 40 + i, i, i + 1); #1;
      chk("fill_idx", ROB_idx, i);
      chk("fill_valid", ROB_valid, 1);
    end
    @(negedge clock); idle(); disp(60, 61, 3, 4); #1;
    chk("full_valid", ROB_valid, 0);
    @(negedge clock); idle(); comp(0); #1;
    chk("full_tail_kept", ROB_idx, 0);
    chk("full_valid2", ROB_valid, 0);
    chk("full_noret", retire_en, 0);
    @(negedge clock); idle(); disp(50, 58, 9, 10); #1;
    chk("fr_ret", retire_en, 1);
    chk("fr_valid", ROB_valid, 1);
    chk("fr_told", retire_Told_idx, 40);
    chk("fr_idx", ROB_idx, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock); idle(); comp((j + 1) % 8); #1;
      if (j == 0) begin
        chk("fr_full_after", ROB_valid, 0);
        chk("fr_tail", ROB_idx, 1);
      end
      chk("fr_seq_ret", retire_en, (j > 0) ? 1 : 0);
      if (j > 0) chk("fr_seq_T", retire_T_idx, 32 + j);
    end
    @(negedge clock); idle(); #1;
    chk("fr_new_ret", retire_en, 1);
    chk("fr_new_T", retire_T_idx, 50);
    @(negedge clock); idle(); #1;
    chk("fr_empty", retire_en, 0);

    // Asynchronous reset mid-run with 5 live entries
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); idle(); disp(10 + i, 20 + i, i, i + 1);
    end
    @(negedge clock); idle(); comp(0);
    @(negedge clock); idle(); #1;
    chk("pre_rst_ret", retire_en, 1);
    reset = 0; rollback_ROB_idx = 2; #1;
    chk("mid_rst_ret", retire_en, 0);
    chk("mid_rst_valid", ROB_valid, 1);
    chk("mid_rst_idx", ROB_idx, 0);
    chk("mid_rst_rT", retire_T_idx, 0);
    chk("mid_rst_fl", FL_rollback_idx, 0);
    @(negedge clock); idle(); reset = 1; disp(20, 21, 1, 2); #1;
    chk("post_rst_idx", ROB_idx, 0);
    @(negedge clock); idle(); #1;
    chk("post_rst_idx1", ROB_idx, 1);
    chk("post_rst_ret", retire_en, 0);

    // Rollback to entry 2 with 6 live; dispatch same cycle ignored
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); idle(); disp(32 + i, i, i, i + 1);
    end
    @(negedge clock); idle(); rollback_en = 1; rollback_ROB_idx = 2; disp(63, 0, 0, 0); #1;
    chk("rb_fl", FL_rollback_idx, 3);
    @(negedge clock); idle(); comp(4); #1;
    chk("rb_tail", ROB_idx, 3);
    chk("rb_valid", ROB_valid, 1);
    @(negedge clock); idle();
    for (int i = 0; i < 5; i++) begin
      disp(40 + i, 0, 0, 0); #1;
      chk("rb_refill_idx", ROB_idx, 3 + i);
      chk("rb_refill_valid", ROB_valid, 1);
      @(negedge clock); idle();
    end
    #1;
    chk("rb_count_full", ROB_valid, 0);
    chk("rb_wrap_idx", ROB_idx, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock); idle(); comp(j); #1;
      chk("rb_ret", retire_en, (j > 0) ? 1 : 0);
      if (j > 0) chk("rb_ret_T", retire_T_idx, 31 + j);
    end
    @(negedge clock); idle(); #1;
    chk("rb_ret3", retire_en, 1);
    chk("rb_ret3_T", retire_T_idx, 40);
    @(negedge clock); idle(); #1;
    chk("rb_stop", retire_en, 0);

    // Rollback onto a retiring head empties the ROB
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); idle(); disp(32 + i, 0, 0, 7 + i);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clock); idle(); comp(j);
    end
    @(negedge clock); idle(); rollback_en = 1; rollback_ROB_idx = 2; #1;
    chk("rbh_ret", retire_en, 1);
    chk("rbh_T", retire_T_idx, 34);
    chk("rbh_fl", FL_rollback_idx, 9);
    @(negedge clock); idle(); #1;
    chk("rbh_empty_ret", retire_en, 0);
    chk("rbh_tail", ROB_idx, 3);
    for (int i = 0; i < 8; i++) begin
      chk("rbh_room", ROB_valid, 1);
      disp(i, 0, 0, 0); #1;
      @(negedge clock); idle(); #1;
    end
    chk("rbh_full", ROB_valid, 0);

    // Random run against a queue model
    do_reset();
    q.delete(); mhead = 0;
    for (int c = 0; c < 3000; c++) begin
      bit eret, evld, ren;
      int eidx, roff, off;
      ent_t e;
      @(negedge clock); idle();
      eret = (q.size() > 0) && q[0].done;
      evld = (q.size() < N) || eret;
      eidx = (mhead + q.size()) % N;
      e.t = $urandom_range(0, 63); e.told = $urandom_range(0, 63);
      e.dest = $urandom_range(0, 31); e.fl = $urandom_range(0, 31); e.done = 0;
      if ($urandom_range(0, 3) != 0) disp(e.t, e.told, e.dest, e.fl);
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          comp((mhead + $urandom_range(0, q.size() - 1)) % N);
        else
          comp($urandom_range(0, N - 1));
      end
      ren = 0; roff = 0;
      if (q.size() > 0 && $urandom_range(0, 15) == 0) begin
        ren = 1;
        roff = $urandom_range(0, q.size() - 1);
        rollback_en = 1;
        rollback_ROB_idx = 3'((mhead + roff) % N);
      end
      #1;
      chk("rnd_valid", ROB_valid, evld);
      chk("rnd_idx", ROB_idx, eidx);
      chk("rnd_ret", retire_en, eret);
      if (eret) begin
        chk("rnd_rT", retire_T_idx, q[0].t);
        chk("rnd_rTold", retire_Told_idx, q[0].told);
        chk("rnd_rdest", retire_dest_idx, q[0].dest);
      end
      if (ren) chk("rnd_fl", FL_rollback_idx, q[roff].fl);
      if (complete_en) begin
        off = (int'(complete_ROB_idx) - mhead + N) % N;
        if (off < q.size()) q[off].done = 1;
      end
      if (ren) while (q.size() > roff + 1) void'(q.pop_back());
      if (eret) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % N;
      end
      if (dispatch_en && evld && !ren) q.push_back(e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
